// File: rtl/bcd_conv64_pkg.sv
// Shared constants for the binary <-> packed-BCD converter.
// Opcode and size encodings, FSM state codes and the per-size iteration count.
// Imported by the converter top and its digit adjuster.
package bcd_conv64_pkg;

   // Default geometry: widest binary operand and BCD accumulator digits (10^20 > 2^64)
   localparam int DEF_MAXW = 64;
   localparam int DEF_NDIG = 20;

   // Operation codes on OpCODE; all other encodings are reserved
   localparam logic [2:0] OP_BIN2BCD = 3'b000;
   localparam logic [2:0] OP_BCD2BIN = 3'b001;

   // Operand size codes carried on SA[1:0] / SR[1:0]
   localparam logic [1:0] SZ8  = 2'b00;
   localparam logic [1:0] SZ16 = 2'b01;
   localparam logic [1:0] SZ32 = 2'b10;
   localparam logic [1:0] SZ64 = 2'b11;

   // FSM state codes
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Number of one-bit iterations for a size code: 8, 16, 32 or 64
   function automatic logic [6:0] iter_count(input logic [1:0] size);
      return 7'd8 << size;
   endfunction

endpackage

// File: rtl/bcd_conv64_digit_adj.sv
// Single BCD digit correction used by both conversion directions.
// Upward (double-dabble): digit >= 5 gets +3. Downward (reverse): digit >= 8 gets -3.
// Purely combinational; no state, no handshake.
module bcd_digit_adj (
   input  logic       down_i,
   input  logic [3:0] dig_i,
   output logic [3:0] dig_o
);

   // Select the correction for the active direction, otherwise pass the digit through
   always_comb begin
      dig_o = dig_i;
      if (down_i) begin
         if (dig_i >= 4'd8) dig_o = dig_i - 4'd3;
      end else begin
         if (dig_i >= 4'd5) dig_o = dig_i + 4'd3;
      end
   end

endmodule

// File: rtl/bcd_conv64.sv
// Multi-cycle binary <-> packed-BCD converter on the misc-unit result bus.
// Latency: N clocks (N = 8/16/32/64) from accept to RDY; 1 clock for invalid BCD or reserved opcode.
// ACT is only sampled while BUSY=0; requests arriving while busy are dropped, not queued.
module bcd_conv64
   import bcd_conv64_pkg::*;
#(
   parameter int MAXW = DEF_MAXW,
   parameter int NDIG = DEF_NDIG
) (
   input  logic         CLK,
   input  logic         RESETn,
   input  logic         ACT,
   input  logic [2:0]   OpCODE,
   input  logic [2:0]   SA,
   input  logic [3:0]   DSTi,
   input  logic [127:0] A,
   output logic         BUSY,
   output logic         RDY,
   output logic         ZERO,
   output logic         SIGN,
   output logic         OVR,
   output logic         COUT,
   output logic [2:0]   SR,
   output logic [3:0]   DSTo,
   output logic [127:0] R
);

   localparam int ACCW = 4 * NDIG;

   // Architectural state
   logic [0:0]      state_q, state_d;
   logic [6:0]      cnt_q, cnt_d;
   logic            down_q, down_d;
   logic [1:0]      size_q, size_d;
   logic [3:0]      dst_q, dst_d;
   logic [ACCW-1:0] acc_q, acc_d;
   logic [MAXW-1:0] sh_q, sh_d;
   logic            err_q, err_d;

   // Registered result bus
   logic            rdy_q, rdy_d;
   logic            zero_q, zero_d;
   logic            ovr_q, ovr_d;
   logic            cout_q, cout_d;
   logic [2:0]      sr_q, sr_d;
   logic [3:0]      dsto_q, dsto_d;
   logic [127:0]    r_q, r_d;

   // Upper operand half and SA[2] carry no meaning for this unit
   logic            unused_in;
   assign unused_in = ^{A[127:MAXW], SA[2]};

   logic            busy;
   assign busy = (state_q == ST_RUN) || err_q;

   // Accept-side decode: operand width, mask, alignment shift
   logic [6:0]      n_bits;
   logic [6:0]      lsh;
   logic [MAXW-1:0] mask;
   logic [MAXW-1:0] opnd;
   logic            bcd_bad;
   logic            op_ok;

   assign n_bits = iter_count(SA[1:0]);
   assign lsh    = 7'(MAXW) - n_bits;

   // Build the size mask and flag any non-decimal digit inside the masked operand
   always_comb begin
      mask    = '0;
      bcd_bad = 1'b0;
      for (int i = 0; i < MAXW; i++) begin
         mask[i] = (7'(i) < n_bits);
      end
      opnd = A[MAXW-1:0] & mask;
      for (int d = 0; d < MAXW / 4; d++) begin
         if (opnd[4*d +: 4] > 4'd9) bcd_bad = 1'b1;
      end
   end

   assign op_ok = (OpCODE == OP_BIN2BCD) ||
                  ((OpCODE == OP_BCD2BIN) && !bcd_bad);

   // Load values: BIN2BCD left-aligns the operand in the shifter so its MSB leaves first;
   // BCD2BIN places the digits in the accumulator and collects bits at the shifter top
   logic [ACCW-1:0] load_acc;
   logic [MAXW-1:0] load_sh;

   // Pick initial accumulator / shifter contents for the requested direction
   always_comb begin
      load_acc = '0;
      load_sh  = '0;
      if (OpCODE == OP_BCD2BIN) begin
         load_acc[MAXW-1:0] = opnd;
      end else begin
         load_sh = opnd << lsh;
      end
   end

   // Iteration datapath; one shared set of digit adjusters serves both directions.
   // Upward corrects before the shift, downward corrects the digits after the shift.
   logic [ACCW-1:0] adj_in;
   logic [ACCW-1:0] adj_out;
   logic [ACCW-1:0] acc_step;
   logic [MAXW-1:0] sh_step;

   assign adj_in = down_q ? (acc_q >> 1) : acc_q;

   for (genvar g = 0; g < NDIG; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .down_i (down_q),
         .dig_i  (adj_in[4*g +: 4]),
         .dig_o  (adj_out[4*g +: 4])
      );
   end

   // Form the post-iteration accumulator and shifter
   always_comb begin
      if (down_q) begin
         acc_step = adj_out;
         sh_step  = {acc_q[0], sh_q[MAXW-1:1]};
      end else begin
         {acc_step, sh_step} = {adj_out, sh_q} << 1;
      end
   end

   // Completion values, valid on the final iteration
   logic [6:0]   n_bits_q;
   logic [6:0]   lsh_q;
   logic [127:0] res;
   logic         cout_calc;

   assign n_bits_q = iter_count(size_q);
   assign lsh_q    = 7'(MAXW) - n_bits_q;

   // Assemble the result word and the does-not-fit-same-size flag
   always_comb begin
      res       = '0;
      cout_calc = 1'b0;
      if (down_q) begin
         res[MAXW-1:0] = sh_step >> lsh_q;
      end else begin
         res[ACCW-1:0] = acc_step;
         // N binary bits map to 2*N/8 digits = N accumulator bits; anything above overflows
         cout_calc     = |(acc_step >> n_bits_q);
      end
   end

   // Next-state: error completion, RUN iteration, or accept from IDLE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      down_d  = down_q;
      size_d  = size_q;
      dst_d   = dst_q;
      acc_d   = acc_q;
      sh_d    = sh_q;
      err_d   = 1'b0;
      rdy_d   = 1'b0;
      zero_d  = zero_q;
      ovr_d   = ovr_q;
      cout_d  = cout_q;
      sr_d    = sr_q;
      dsto_d  = dsto_q;
      r_d     = r_q;
      if (err_q) begin
         // Rejected request completes one clock after accept without iterating
         rdy_d  = 1'b1;
         r_d    = '0;
         zero_d = 1'b1;
         ovr_d  = 1'b1;
         cout_d = 1'b0;
         sr_d   = {1'b0, size_q};
         dsto_d = dst_q;
      end else if (state_q == ST_RUN) begin
         acc_d = acc_step;
         sh_d  = sh_step;
         cnt_d = cnt_q - 7'd1;
         if (cnt_q == 7'd1) begin
            state_d = ST_IDLE;
            rdy_d   = 1'b1;
            r_d     = res;
            zero_d  = (res == '0);
            ovr_d   = 1'b0;
            cout_d  = down_q ? 1'b0 : cout_calc;
            sr_d    = {1'b0, size_q};
            dsto_d  = dst_q;
         end
      end else if (ACT) begin
         down_d = (OpCODE == OP_BCD2BIN);
         size_d = SA[1:0];
         dst_d  = DSTi;
         if (!op_ok) begin
            err_d = 1'b1;
         end else begin
            state_d = ST_RUN;
            cnt_d   = n_bits;
            acc_d   = load_acc;
            sh_d    = load_sh;
         end
      end
   end

   // State and result registers; reset aborts any conversion in flight
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         down_q  <= 1'b0;
         size_q  <= '0;
         dst_q   <= '0;
         acc_q   <= '0;
         sh_q    <= '0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b0;
         zero_q  <= 1'b0;
         ovr_q   <= 1'b0;
         cout_q  <= 1'b0;
         sr_q    <= '0;
         dsto_q  <= '0;
         r_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         down_q  <= down_d;
         size_q  <= size_d;
         dst_q   <= dst_d;
         acc_q   <= acc_d;
         sh_q    <= sh_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
         zero_q  <= zero_d;
         ovr_q   <= ovr_d;
         cout_q  <= cout_d;
         sr_q    <= sr_d;
         dsto_q  <= dsto_d;
         r_q     <= r_d;
      end
   end

   assign BUSY = busy;
   assign RDY  = rdy_q;
   assign ZERO = zero_q;
   assign SIGN = 1'b0;
   assign OVR  = ovr_q;
   assign COUT = cout_q;
   assign SR   = sr_q;
   assign DSTo = dsto_q;
   assign R    = r_q;

endmodule

// File: tb/tb_bcd_conv64.sv
// Directed bench for bcd_conv64: reset, both conversion directions, rejects,
// back-to-back acceptance with ACT held high, and reset abort mid-conversion.
module tb_bcd_conv64;

   logic         CLK;
   logic         RESETn;
   logic         ACT;
   logic [2:0]   OpCODE;
   logic [2:0]   SA;
   logic [3:0]   DSTi;
   logic [127:0] A;
   logic         BUSY, RDY, ZERO, SIGN, OVR, COUT;
   logic [2:0]   SR;
   logic [3:0]   DSTo;
   logic [127:0] R;

   int checks = 0;
   int errors = 0;

   bcd_conv64 dut (
      .CLK    (CLK),
      .RESETn (RESETn),
      .ACT    (ACT),
      .OpCODE (OpCODE),
      .SA     (SA),
      .DSTi   (DSTi),
      .A      (A),
      .BUSY   (BUSY),
      .RDY    (RDY),
      .ZERO   (ZERO),
      .SIGN   (SIGN),
      .OVR    (OVR),
      .COUT   (COUT),
      .SR     (SR),
      .DSTo   (DSTo),
      .R      (R)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Issue one request and wait for RDY; lat = posedges after the accept edge (999 on timeout)
   task automatic run_op(input logic [2:0] op, input logic [1:0] sa, input logic [3:0] dst,
                         input logic [63:0] a, output int lat);
      @(negedge CLK);
      ACT    = 1'b1;
      OpCODE = op;
      SA     = {1'b1, sa};
      DSTi   = dst;
      A      = {64'hA5A5_5A5A_F00D_BEEF, a};
      @(negedge CLK);
      ACT = 1'b0;
      lat = 0;
      while (RDY !== 1'b1 && lat < 200) begin
         @(negedge CLK);
         lat++;
      end
      if (lat >= 200) lat = 999;
   endtask

   task automatic test_reset();
      RESETn = 1'b0; ACT = 1'b0; OpCODE = 3'd0; SA = 3'd0; DSTi = 4'd0; A = '0;
      repeat (3) @(negedge CLK);
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
      checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", RDY); end
      checks++; if (R !== 128'd0) begin errors++; $display("FAIL reset_r got %h exp 0", R); end
      checks++; if ({ZERO, SIGN, OVR, COUT} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {ZERO, SIGN, OVR, COUT}); end
      checks++; if ({SR, DSTo} !== 7'd0) begin errors++; $display("FAIL reset_sr_dst got %h exp 0", {SR, DSTo}); end
      RESETn = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_bin2bcd();
      int lat;
      // 255 -> 0x255, does not fit two digits
      run_op(3'b000, 2'b00, 4'd5, 64'h0000_0000_1234_56FF, lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL b2b8_lat got %0d exp 8", lat); end
      checks++; if (R !== 128'h255) begin errors++; $display("FAIL b2b8_r got %h exp 255", R); end
      checks++; if ({COUT, ZERO, OVR} !== 3'b100) begin errors++; $display("FAIL b2b8_flags got %b exp 100", {COUT, ZERO, OVR}); end
      checks++; if ({SR, DSTo} !== {3'd0, 4'd5}) begin errors++; $display("FAIL b2b8_tag got %h exp 05", {SR, DSTo}); end
      checks++; if (SIGN !== 1'b0) begin errors++; $display("FAIL b2b8_sign got %b exp 0", SIGN); end
      @(negedge CLK);
      checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL b2b8_rdy_pulse got %b exp 0", RDY); end
      checks++; if (R !== 128'h255) begin errors++; $display("FAIL b2b8_hold got %h exp 255", R); end
      // 2^64-1 at full width
      run_op(3'b000, 2'b11, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, lat);
      checks++; if (lat !== 64) begin errors++; $display("FAIL b2b64_lat got %0d exp 64", lat); end
      checks++; if (R !== 128'h18446744073709551615) begin errors++; $display("FAIL b2b64_r got %h exp 18446744073709551615", R); end
      checks++; if (COUT !== 1'b1) begin errors++; $display("FAIL b2b64_cout got %b exp 1", COUT); end
      // Zero at 16 bits, junk above bit 15 must be masked off
      run_op(3'b000, 2'b01, 4'd2, 64'h0000_ABCD_0000_0000, lat);
      checks++; if (lat !== 16) begin errors++; $display("FAIL b2b16_lat got %0d exp 16", lat); end
      checks++; if (R !== 128'd0) begin errors++; $display("FAIL b2b16_r got %h exp 0", R); end
      checks++; if ({ZERO, COUT} !== 2'b10) begin errors++; $display("FAIL b2b16_flags got %b exp 10", {ZERO, COUT}); end
   endtask

   task automatic test_bcd2bin();
      int lat;
      run_op(3'b001, 2'b01, 4'd7, 64'h0000_0000_0000_9999, lat);
      checks++; if (lat !== 16) begin errors++; $display("FAIL d2b16_lat got %0d exp 16", lat); end
      checks++; if (R !== 128'h270F) begin errors++; $display("FAIL d2b16_r got %h exp 270f", R); end
      checks++; if ({COUT, OVR, ZERO} !== 3'b000) begin errors++; $display("FAIL d2b16_flags got %b exp 000", {COUT, OVR, ZERO}); end
      checks++; if ({SR, DSTo} !== {3'd1, 4'd7}) begin errors++; $display("FAIL d2b16_tag got %h exp 17", {SR, DSTo}); end
      run_op(3'b001, 2'b11, 4'd8, 64'h1234_5678_9012_3456, lat);
      checks++; if (lat !== 64) begin errors++; $display("FAIL d2b64_lat got %0d exp 64", lat); end
      checks++; if (R !== 128'h462D53C8ABAC0) begin errors++; $display("FAIL d2b64_r got %h exp 462d53c8abac0", R); end
   endtask

   task automatic test_invalid();
      int lat;
      run_op(3'b001, 2'b10, 4'd4, 64'h0000_0000_0012_3A45, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL badbcd_lat got %0d exp 1", lat); end
      checks++; if (R !== 128'd0) begin errors++; $display("FAIL badbcd_r got %h exp 0", R); end
      checks++; if ({OVR, ZERO, COUT} !== 3'b110) begin errors++; $display("FAIL badbcd_flags got %b exp 110", {OVR, ZERO, COUT}); end
      checks++; if ({SR, DSTo} !== {3'd2, 4'd4}) begin errors++; $display("FAIL badbcd_tag got %h exp 24", {SR, DSTo}); end
      @(negedge CLK);
      checks++; if (RDY !== 1'b0) begin errors++; $display("FAIL badbcd_rdy_pulse got %b exp 0", RDY); end
      run_op(3'b101, 2'b00, 4'd6, 64'h0000_0000_0000_00FF, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL resop_lat got %0d exp 1", lat); end
      checks++; if ({R == 128'd0, OVR, ZERO} !== 3'b111) begin errors++; $display("FAIL resop_res got r=%h ovr=%b zero=%b exp r=0 ovr=1 zero=1", R, OVR, ZERO); end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge CLK);
      ACT = 1'b1; OpCODE = 3'b000; SA = 3'b001; DSTi = 4'd3; A = 128'h1234;
      @(negedge CLK);
      // Second request presented while busy; must wait for the RDY cycle
      OpCODE = 3'b000; SA = 3'b000; DSTi = 4'd9; A = 128'h63;
      checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", BUSY); end
      lat = 0;
      while (RDY !== 1'b1 && lat < 200) begin @(negedge CLK); lat++; end
      checks++; if (lat !== 16) begin errors++; $display("FAIL b2b_first_lat got %0d exp 16", lat); end
      checks++; if (R !== 128'h4660) begin errors++; $display("FAIL b2b_first_r got %h exp 4660", R); end
      checks++; if ({SR, DSTo} !== {3'd1, 4'd3}) begin errors++; $display("FAIL b2b_first_tag got %h exp 13", {SR, DSTo}); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL b2b_rdy_busy got %b exp 0", BUSY); end
      @(negedge CLK);
      ACT = 1'b0;
      lat = 0;
      while (RDY !== 1'b1 && lat < 200) begin @(negedge CLK); lat++; end
      checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_second_lat got %0d exp 8", lat); end
      checks++; if (R !== 128'h99) begin errors++; $display("FAIL b2b_second_r got %h exp 99", R); end
      checks++; if ({SR, DSTo, COUT} !== {3'd0, 4'd9, 1'b0}) begin errors++; $display("FAIL b2b_second_tag got %h exp 12", {SR, DSTo, COUT}); end
   endtask

   task automatic test_reset_abort();
      int lat;
      int seen;
      @(negedge CLK);
      ACT = 1'b1; OpCODE = 3'b000; SA = 3'b011; DSTi = 4'd2; A = {64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
      @(negedge CLK);
      ACT = 1'b0;
      repeat (30) @(negedge CLK);
      RESETn = 1'b0;
      #1;
      checks++; if ({BUSY, RDY} !== 2'b00) begin errors++; $display("FAIL abort_busy_rdy got %b exp 00", {BUSY, RDY}); end
      checks++; if (R !== 128'd0) begin errors++; $display("FAIL abort_r got %h exp 0", R); end
      checks++; if ({ZERO, OVR, COUT, SR, DSTo} !== 10'd0) begin errors++; $display("FAIL abort_flags got %h exp 0", {ZERO, OVR, COUT, SR, DSTo}); end
      @(negedge CLK);
      RESETn = 1'b1;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge CLK);
         if (RDY === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_rdy got %0d pulses exp 0", seen); end
      run_op(3'b000, 2'b00, 4'd1, 64'h2A, lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL post_abort_lat got %0d exp 8", lat); end
      checks++; if (R !== 128'h42) begin errors++; $display("FAIL post_abort_r got %h exp 42", R); end
   endtask

   initial begin
      test_reset();
      test_bin2bcd();
      test_bcd2bin();
      test_invalid();
      test_back_to_back();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
